// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester round-robin register-file write arbiter with clear sequence
//
// Purpose: merges writes from two requesters onto one register-file write port.
//          A flash request replaces arbitration with one clear write per register.
//          Every output is registered, so a grant is seen one cycle after the request.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req0/addr0/data0    requester 0 write request, held until gnt0 is seen
//   req1/addr1/data1    requester 1 write request, held until gnt1 is seen
//   flash_req           request to clear every register to zero
//   gnt0, gnt1          one-cycle pulse: that requester's write is on the port this cycle
//   wb_en/wb_addr/wr_data  register-file write port
//   flash_busy          high on every clear write cycle
//   flash_done          one-cycle pulse after the final clear write
module wb_arbiter #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    input  logic          flash_req,
    output logic          gnt0,
    output logic          gnt1,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wr_data,
    output logic          flash_busy,
    output logic          flash_done
);

    typedef enum logic {IDLE, FLASH} state_t;

    // One extra bit lets the counter reach 2**AW, which marks the
    // flash_done cycle without needing a third state.
    localparam logic [AW:0] CLR_END = (AW+1)'(1) << AW;

    state_t      state;
    logic [AW:0] clr_cnt;
    logic        rr_ptr;    // 1: requester 1 wins a tie, 0: requester 0 wins a tie
    logic        elig0;
    logic        elig1;
    logic        pick1;

    // A requester whose grant is showing right now is still holding the
    // request it was just served for, so it must not be served again.
    always_comb begin
        elig0 = req0 & ~gnt0;
        elig1 = req1 & ~gnt1;
        pick1 = elig1 & (~elig0 | rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            rr_ptr     <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wr_data    <= '0;
            flash_busy <= 1'b0;
            flash_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flash_busy <= 1'b0;
                    flash_done <= 1'b0;
                    if (flash_req) begin
                        state   <= FLASH;
                        clr_cnt <= '0;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        wb_en   <= 1'b0;
                    end else begin
                        gnt0  <= elig0 & ~pick1;
                        gnt1  <= pick1;
                        wb_en <= elig0 | elig1;
                        // Address and data hold their last values on idle cycles.
                        if (elig0 | elig1) begin
                            wb_addr <= pick1 ? addr1 : addr0;
                            wr_data <= pick1 ? data1 : data0;
                            rr_ptr  <= ~pick1;
                        end
                    end
                end
                FLASH: begin
                    // Requests and flash_req are ignored here; held requests
                    // are picked up again once the state returns to IDLE.
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    if (clr_cnt == CLR_END) begin
                        wb_en      <= 1'b0;
                        flash_busy <= 1'b0;
                        flash_done <= 1'b1;
                        clr_cnt    <= '0;
                        state      <= IDLE;
                    end else begin
                        wb_en      <= 1'b1;
                        wb_addr    <= clr_cnt[AW-1:0];
                        wr_data    <= '0;
                        flash_busy <= 1'b1;
                        clr_cnt    <= clr_cnt + (AW+1)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with behavioural model
module tb_wb_arbiter;
    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, flash_req;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1, wb_en, flash_busy, flash_done;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .flash_req(flash_req),
        .gnt0(gnt0), .gnt1(gnt1), .wb_en(wb_en),
        .wb_addr(wb_addr), .wr_data(wr_data),
        .flash_busy(flash_busy), .flash_done(flash_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: clear_idx = -1 when arbitrating, otherwise the
    // number of clear writes already issued in the current sequence.
    bit            m_g0, m_g1, m_en, m_busy, m_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            clear_idx   = -1;
    int            last_served = 1;
    bit            cmp_en      = 1'b0;

    always @(posedge clk) begin
        bit e0, e1;
        int win;
        if (rst) begin
            {m_g0, m_g1, m_en, m_busy, m_done} = '0;
            m_addr = '0; m_data = '0;
            clear_idx = -1; last_served = 1;
        end else if (clear_idx >= 0) begin
            m_g0 = 0; m_g1 = 0;
            if (clear_idx < NREG) begin
                m_en = 1; m_addr = clear_idx[AW-1:0]; m_data = '0;
                m_busy = 1; m_done = 0;
                clear_idx++;
            end else begin
                m_en = 0; m_busy = 0; m_done = 1;
                clear_idx = -1;
            end
        end else if (flash_req) begin
            {m_g0, m_g1, m_en, m_busy, m_done} = '0;
            clear_idx = 0;
        end else begin
            e0 = req0 && !m_g0;
            e1 = req1 && !m_g1;
            if (e0 && e1)  win = (last_served == 0) ? 1 : 0;
            else if (e0)   win = 0;
            else if (e1)   win = 1;
            else           win = -1;
            m_busy = 0; m_done = 0;
            m_g0 = (win == 0);
            m_g1 = (win == 1);
            m_en = (win >= 0);
            if (win == 0) begin m_addr = addr0; m_data = data0; last_served = 0; end
            if (win == 1) begin m_addr = addr1; m_data = data1; last_served = 1; end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gnt0", gnt0, m_g0);
            chk("gnt1", gnt1, m_g1);
            chk("wb_en", wb_en, m_en);
            chk("wb_addr", wb_addr, m_addr);
            chk("wr_data", wr_data, m_data);
            chk("flash_busy", flash_busy, m_busy);
            chk("flash_done", flash_done, m_done);
            chk("both_grants", gnt0 & gnt1, 0);
            if (!flash_busy) chk("wb_en_vs_gnt", wb_en, gnt0 | gnt1);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; req0 = 0; req1 = 0; flash_req = 0;
        cyc();
        rst = 0;
    endtask

    initial begin
        bit p0, p1;
        rst = 1; req0 = 0; req1 = 0; flash_req = 0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        cyc();
        cmp_en = 1;
        chk("rst_wb_en", wb_en, 0);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_busy", flash_busy, 0);
        chk("rst_addr", wb_addr, 0);
        rst = 0;

        // single requester 0
        req0 = 1; addr0 = 2; data0 = 8'h5A;
        cyc();
        chk("r36_gnt0", gnt0, 1);
        chk("r36_en", wb_en, 1);
        chk("r36_addr", wb_addr, 2);
        chk("r36_data", wr_data, 8'h5A);
        req0 = 0;
        cyc();
        chk("r36_en_off", wb_en, 0);
        chk("r36_addr_hold", wb_addr, 2);

        // both held continuously alternate
        do_reset();
        req0 = 1; addr0 = 0; data0 = 8'h11;
        req1 = 1; addr1 = 1; data1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("r37_gnt0", gnt0, (i % 2 == 0));
            chk("r37_gnt1", gnt1, (i % 2 == 1));
            chk("r37_en", wb_en, 1);
            chk("r37_data", wr_data, (i % 2 == 0) ? 8'h11 : 8'h22);
        end
        req0 = 0; req1 = 0;
        cyc();

        // flash pulse with req1 pending
        do_reset();
        req1 = 1; addr1 = 3; data1 = 8'h77; flash_req = 1;
        cyc();
        flash_req = 0;
        chk("r38_entry_en", wb_en, 0);
        chk("r38_entry_busy", flash_busy, 0);
        for (int i = 0; i < NREG; i++) begin
            cyc();
            chk("r38_en", wb_en, 1);
            chk("r38_addr", wb_addr, i);
            chk("r38_data", wr_data, 0);
            chk("r38_busy", flash_busy, 1);
            chk("r38_gnt1_off", gnt1, 0);
        end
        cyc();
        chk("r38_done", flash_done, 1);
        chk("r38_done_busy", flash_busy, 0);
        chk("r38_done_en", wb_en, 0);
        cyc();
        chk("r38_gnt1", gnt1, 1);
        chk("r38_g_addr", wb_addr, 3);
        chk("r38_g_data", wr_data, 8'h77);
        req1 = 0;
        cyc();

        // flash_req held through the whole sequence
        do_reset();
        flash_req = 1;
        cyc();
        for (int i = 0; i < NREG; i++) begin
            cyc();
            chk("r39_addr", wb_addr, i);
            chk("r39_busy", flash_busy, 1);
        end
        cyc();
        chk("r39_done", flash_done, 1);
        cyc();
        chk("r39_reentry_busy", flash_busy, 0);
        chk("r39_reentry_en", wb_en, 0);
        cyc();
        chk("r39_second_busy", flash_busy, 1);
        chk("r39_second_addr", wb_addr, 0);
        flash_req = 0;

        // reset aborts a clear sequence
        do_reset();
        flash_req = 1;
        cyc();
        flash_req = 0;
        cyc();
        cyc();
        chk("r40_addr1", wb_addr, 1);
        rst = 1;
        cyc();
        rst = 0;
        chk("r40_en", wb_en, 0);
        chk("r40_addr", wb_addr, 0);
        chk("r40_busy", flash_busy, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("r40_no_resume", wb_en | flash_busy | flash_done, 0);
        end

        // pointer after a requester 1 service favours requester 0
        do_reset();
        req1 = 1; addr1 = 1; data1 = 8'h33;
        cyc();
        chk("r41_gnt1", gnt1, 1);
        req1 = 0;
        cyc();
        req0 = 1; addr0 = 2; data0 = 8'h44;
        req1 = 1; addr1 = 3; data1 = 8'h55;
        cyc();
        chk("r41_gnt0", gnt0, 1);
        chk("r41_gnt1_off", gnt1, 0);
        req0 = 0; req1 = 0;
        cyc();

        // randomized traffic following the hold-until-grant protocol
        do_reset();
        p0 = 0; p1 = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (p0 && m_g0) p0 = 0;
            if (p1 && m_g1) p1 = 0;
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; addr0 = AW'($urandom); data0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; addr1 = AW'($urandom); data1 = DW'($urandom);
            end
            req0 = p0; req1 = p1;
            flash_req = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 0; req0 = 0; req1 = 0; flash_req = 0;
        repeat (8) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DW, default 8, data width of register file write port.
REQ-002 Parameter AW, default 2, register address width (2**AW registers).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req0  input  1  requester 0 write request; held high with addr0/data0 stable until gnt0 seen.
REQ-006 addr0  input  AW  requester 0 destination register.
REQ-007 data0  input  DW  requester 0 write data.
REQ-008 req1  input  1  requester 1 write request, same rules as req0.
REQ-009 addr1  input  AW  requester 1 destination register.
REQ-010 data1  input  DW  requester 1 write data.
REQ-011 flash_req  input  1  request to clear all registers to zero.
REQ-012 gnt0  output  1  one-cycle pulse: requester 0 write issued this cycle.
REQ-013 gnt1  output  1  one-cycle pulse: requester 1 write issued this cycle.
REQ-014 wb_en  output  1  register file write enable.
REQ-015 wb_addr  output  AW  register file write address.
REQ-016 wr_data  output  DW  register file write data.
REQ-017 flash_busy  output  1  high while clear sequence in progress.
REQ-018 flash_done  output  1  one-cycle pulse after final clear write.

Function
REQ-019 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-020 States SHALL be IDLE and FLASH.
REQ-021 IDLE: at each edge, if flash_req=1 the block SHALL enter FLASH with clear counter=0, ignoring req0/req1 that edge.
REQ-022 IDLE, flash_req=0: eligible requesters SHALL be arbitrated; winner's gnt, wb_en=1, wb_addr=addrX, wr_data=dataX appear in the next cycle (latency 1).
REQ-023 A requester SHALL be ineligible in any cycle its own gnt is high (prevents double issue of a held request).
REQ-024 Both eligible: grant SHALL go to the requester not served last (round-robin pointer); pointer updates only on a grant.
REQ-025 One eligible: it SHALL be granted regardless of pointer.
REQ-026 No eligible request: wb_en, gnt0, gnt1 SHALL be 0 next cycle; wb_addr/wr_data hold last values.
REQ-027 gnt0 and gnt1 SHALL never be high together; wb_en SHALL equal gnt0|gnt1 outside FLASH.
REQ-028 FLASH: one write per cycle, wb_en=1, wr_data=0, wb_addr=counter, counter 0..2**AW-1, gnt0=gnt1=0.
REQ-029 flash_busy SHALL be high from first clear write cycle through last clear write cycle inclusive.
REQ-030 After last clear write, flash_done SHALL pulse one cycle, state returns to IDLE, arbitration resumes same cycle (grant can appear cycle after flash_done).
REQ-031 flash_req during FLASH SHALL be ignored (not queued); counter SHALL not wrap mid-sequence.
REQ-032 Requests pending during FLASH SHALL be held off, not dropped; round-robin pointer SHALL be unchanged by FLASH.

Reset
REQ-033 rst=1 SHALL force IDLE, counter=0, pointer favoring requester 0, and all outputs to 0 at the next edge.
REQ-034 rst SHALL override any in-progress grant or FLASH sequence; an aborted clear is not resumed.
REQ-035 rst SHALL take priority over flash_req and req0/req1 in the same cycle.

Verification
REQ-036 After reset, req0=1 addr0=2 data0=0x5A alone -> next cycle gnt0=1 wb_en=1 wb_addr=2 wr_data=0x5A; following cycle wb_en=0 if req0 dropped.
REQ-037 req0 and req1 held high continuously (data 0x11/0x22) -> gnt0, gnt1, gnt0, gnt1 alternating every cycle, wb_en=1 each cycle, never both grants.
REQ-038 flash_req pulse with req1 pending -> 4 cycles wb_en=1 wr_data=0 wb_addr=0,1,2,3, flash_busy=1, then flash_done=1, then gnt1 one cycle later.
REQ-039 flash_req held high through FLASH -> only one 4-write sequence before re-entry is evaluated in IDLE; no mid-sequence restart.
REQ-040 rst asserted during FLASH at wb_addr=1 -> next cycle all outputs 0, state IDLE, no further clear writes.
REQ-041 req1 only, then req0 and req1 together -> first grant gnt1, then gnt0 (pointer after req1 service favors requester 0).
